// File: rtl/nios_system_avalon_st_adapter_ready_latency_tx.sv
// -----------------------------------------------------------------------------
// nios_system_avalon_st_adapter_ready_latency_tx
//
// Purpose: Avalon-ST timing adapter from a ready-latency-0 source to a sink
// that advertises ready with a ready latency of READY_LATENCY cycles. Beats
// are buffered in a small FIFO. A beat is emitted only in a cycle whose
// ready_slot (out_ready delayed READY_LATENCY cycles) is 1.
//
// Handshake semantics:
//   upstream   : a beat transfers on a rising edge where in_valid && in_ready.
//                in_ready is a function of registers only.
//   downstream : out_ready in cycle t grants a slot in cycle t+READY_LATENCY.
//                out_valid in a granted slot is a transfer; the sink must
//                accept it. out_valid is a function of registers only.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_ready / in_valid     upstream handshake (ready latency 0)
//   in_data/error/sop/eop/empty   32/6/1/1/2-bit upstream payload
//   out_ready               downstream ready (ready latency READY_LATENCY)
//   out_valid               beat presented this cycle
//   out_data/error/sop/eop/empty  head-of-FIFO payload
//   fill_level              beats currently stored
// -----------------------------------------------------------------------------
module nios_system_avalon_st_adapter_ready_latency_tx #(
  parameter int READY_LATENCY = 2,  // 1..8
  parameter int FIFO_DEPTH    = 4   // power of two, 2..16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  output logic                          in_ready,
  input  logic                          in_valid,
  input  logic [31:0]                   in_data,
  input  logic [5:0]                    in_error,
  input  logic                          in_startofpacket,
  input  logic                          in_endofpacket,
  input  logic [1:0]                    in_empty,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [31:0]                   out_data,
  output logic [5:0]                    out_error,
  output logic                          out_startofpacket,
  output logic                          out_endofpacket,
  output logic [1:0]                    out_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = 42;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [PW-1:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [READY_LATENCY-1:0] ready_pipe_q, ready_pipe_d;
  logic                     run_q;

  logic          ready_slot;
  logic          push;
  logic          pop;
  logic [PW-1:0] payload_in;
  logic [PW-1:0] payload_head;

  assign payload_in = {in_data, in_error, in_startofpacket, in_endofpacket, in_empty};

  // Oldest stage of the history is out_ready from READY_LATENCY cycles ago.
  assign ready_slot = ready_pipe_q[READY_LATENCY-1];

  // Full-and-popping still reports not-ready: in_ready looks at registered
  // count only, so freed space becomes visible one cycle later.
  assign in_ready  = run_q && (count_q < DEPTH_C);
  assign out_valid = ready_slot && (count_q != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid;

  always_comb begin
    ready_pipe_d    = ready_pipe_q << 1;
    ready_pipe_d[0] = out_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_pipe_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      run_q        <= 1'b0;
    end else begin
      ready_pipe_q <= ready_pipe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      run_q        <= 1'b1;
    end
  end

  // Storage carries no reset: stale contents are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= payload_in;
  end

  assign payload_head = mem_q[rd_ptr_q];
  assign {out_data, out_error, out_startofpacket, out_endofpacket, out_empty} = payload_head;
  assign fill_level = count_q;

endmodule
